// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised raster timing generator.
//
// Walks a horizontal/vertical counter pair over the full raster (active area
// plus porches and sync) on a single clock qualified by a pixel enable. From
// the counter state it registers the (optionally down-scaled) pixel position
// used to address screen RAM / character ROM, plus display-enable and sync
// outputs that are delayed by PIPE extra cycles to line up with the memory
// read latency.
//
// Optional feature: define VGA_TIMING_GEN_IRQ_EN to build the vertical-blank
// interrupt flag. Without it, irq is tied low and irq_ack is ignored.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                pixel-clock enable; all state advances only when high
//   scale             0: 1x, 1: 2x, 2/3: 4x; latched at the start of a frame
//   posx, posy        scaled position, 0 outside the visible area
//   active            position is visible (same stage as posx/posy)
//   de_o, h_sync_o,
//   v_sync_o          display enable and syncs, PIPE cycles after posx
//   line_start        pulse at the first pixel of each line (gated by en)
//   frame_start       pulse at the first pixel of each frame (gated by en)
//   irq, irq_ack      vertical-blank flag and its clear strobe
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE     = 2,
    parameter int   CW       = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    scale,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic          active,
    output logic          de_o,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          line_start,
    output logic          frame_start,
    output logic          irq,
    input  logic          irq_ack
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Pipeline word layout: {de, hsync, vsync}; idle is blank with syncs off.
    localparam logic [2:0] IDLE = {1'b0, ~HS_POL, ~VS_POL};

    logic [CW-1:0] h_cnt, v_cnt;
    logic [1:0]    shift;          // latched scale as a shift amount 0..2
    logic          ls_q, fs_q;
    logic          at_line, at_frame, vis, hs_now, vs_now;
    logic [PIPE:0][2:0] pipe;

    always_comb begin
        at_line  = (h_cnt == '0);
        at_frame = at_line && (v_cnt == '0);
        vis      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_now   = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        // v_cnt only moves when h_cnt wraps to 0, so vsync edges land there.
        vs_now   = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Scale is taken only at the first pixel of a frame. That pixel itself
    // still uses the old shift, which is harmless since its position is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 2'd0;
        end else if (en && at_frame) begin
            shift <= (scale == 2'd0) ? 2'd0 : (scale == 2'd1) ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx   <= '0;
            posy   <= '0;
            active <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else if (en) begin
            posx   <= vis ? (h_cnt >> shift) : '0;
            posy   <= vis ? (v_cnt >> shift) : '0;
            active <= vis;
            ls_q   <= at_line;
            fs_q   <= at_frame;
        end
    end

    // pipe[0] is the same stage as posx; pipe[PIPE] drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE; i++) pipe[i] <= IDLE;
        end else if (en) begin
            pipe[0] <= {vis, hs_now, vs_now};
            for (int i = 1; i <= PIPE; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign de_o     = pipe[PIPE][2];
    assign h_sync_o = pipe[PIPE][1];
    assign v_sync_o = pipe[PIPE][0];

    // Pulses are qualified by en so a held register never reads as a second
    // pulse while the pixel clock is paused.
    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;

`ifdef VGA_TIMING_GEN_IRQ_EN
    // Set on entering the first blank line; ack is honoured every clock,
    // but a coincident set takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (en && at_line && (v_cnt == V_VIS)) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- scoreboard bench for vga_timing_gen.
//
// The driver picks en/scale/irq_ack each cycle (partly at random), advances a
// reference model that derives the raster position from a count of enabled
// cycles (position = count mod frame size), and queues the expected outputs.
// A monitor pops one expectation per clock and compares all outputs.
module tb_vga_timing_gen;

    localparam int   HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int   VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int   PIPE = 2, CW = 11;
    localparam logic HP = 1'b1, VP = 1'b0;
    localparam int   HT = HA + HF + HSW + HB;   // 14
    localparam int   VT = VA + VF + VSW + VB;   // 7
    localparam int   FRAME = HT * VT;           // 98

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          irq_ack = 1'b0;
    logic [1:0]    scale = 2'd0;
    logic [CW-1:0] posx, posy;
    logic          active, de_o, h_sync_o, v_sync_o;
    logic          line_start, frame_start, irq;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .PIPE(PIPE), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .scale(scale),
        .posx(posx), .posy(posy), .active(active), .de_o(de_o),
        .h_sync_o(h_sync_o), .v_sync_o(v_sync_o),
        .line_start(line_start), .frame_start(frame_start),
        .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] posx;
        logic [CW-1:0] posy;
        logic active, de, hs, vs, ls, fs, irq;
    } exp_t;

    exp_t       q[$];
    exp_t       held, me;
    logic [2:0] dq[$];
    int         nen, cur_sh;
    logic       m_irq;
    int         n_cmp = 0, n_bad = 0;
    logic [1:0] sc;
    logic       re;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        nen    = 0;
        cur_sh = 0;
        m_irq  = 1'b0;
        dq.delete();
        for (int i = 0; i < PIPE; i++) dq.push_back({1'b0, ~HP, ~VP});
        held    = '0;
        held.hs = ~HP;
        held.vs = ~VP;
    endtask

    function automatic logic next_set(input logic e);
        return e && ((nen % FRAME) == VA * HT);
    endfunction

    // Expected outputs after the coming clock edge, given the inputs now driven.
    task automatic model_step();
        exp_t       e;
        int         p, h, v;
        logic       vis, set;
        logic [2:0] t;
        e   = held;
        set = 1'b0;
        if (en) begin
            p = nen % FRAME;
            h = p % HT;
            v = p / HT;
            if (p == 0) cur_sh = (scale == 2'd0) ? 0 : (scale == 2'd1) ? 1 : 2;
            vis = (h < HA) && (v < VA);
            e.posx   = vis ? CW'(h >> cur_sh) : '0;
            e.posy   = vis ? CW'(v >> cur_sh) : '0;
            e.active = vis;
            dq.push_back({vis,
                          (h >= HA + HF && h < HA + HF + HSW) ? HP : ~HP,
                          (v >= VA + VF && v < VA + VF + VSW) ? VP : ~VP});
            t    = dq.pop_front();
            e.de = t[2];
            e.hs = t[1];
            e.vs = t[0];
            e.ls = (h == 0);
            e.fs = (p == 0);
            set  = (h == 0) && (v == VA);
            nen++;
        end
`ifdef VGA_TIMING_GEN_IRQ_EN
        if (set) m_irq = 1'b1;
        else if (irq_ack) m_irq = 1'b0;
`else
        m_irq = 1'b0;
`endif
        e.irq = m_irq;
        held  = e;
        if (!en) begin
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic e, input logic [1:0] s, input logic a);
        @(negedge clk);
        rst_n   = 1'b1;
        en      = e;
        scale   = s;
        irq_ack = a;
        model_step();
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            model_reset();
            q.push_back(held);
        end
    endtask

    // Monitor: one expectation per clock, sampled away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("posx",        32'(posx),        32'(me.posx));
                chk("posy",        32'(posy),        32'(me.posy));
                chk("active",      32'(active),      32'(me.active));
                chk("de_o",        32'(de_o),        32'(me.de));
                chk("h_sync_o",    32'(h_sync_o),    32'(me.hs));
                chk("v_sync_o",    32'(v_sync_o),    32'(me.vs));
                chk("line_start",  32'(line_start),  32'(me.ls));
                chk("frame_start", 32'(frame_start), 32'(me.fs));
                chk("irq",         32'(irq),         32'(me.irq));
            end
        end
    end

    initial begin
        sc = 2'd0;
        re = 1'b0;
        model_reset();
        reset_cycles(3);

        // Plain 1x raster for two frames.
        repeat (2 * FRAME) cyc(1'b1, 2'd0, 1'b0);
        // 2x for two frames with sparse acks.
        repeat (2 * FRAME) cyc(1'b1, 2'd1, $urandom_range(0, 19) == 0);
        // Scale changes at arbitrary points mid-frame.
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i % 37 == 11) sc = 2'($urandom_range(0, 3));
            cyc(1'b1, sc, 1'b0);
        end
        // Enable pattern 1,0,0,1 with 4x scale.
        for (int i = 0; i < 4 * FRAME; i++)
            cyc((i % 4 == 0) || (i % 4 == 3), 2'd2, 1'b0);
        // Random enable/scale; ack lands exactly on every set event plus at random.
        for (int i = 0; i < 3 * FRAME; i++) begin
            re = ($urandom_range(0, 3) != 0);
            if (i % 50 == 0) sc = 2'($urandom);
            cyc(re, sc, next_set(re) || ($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset in the middle of a line.
        repeat (23) cyc(1'b1, 2'd0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_posx",   32'(posx),     32'(held.posx));
        chk("async_rst_active", 32'(active),   32'(held.active));
        chk("async_rst_de",     32'(de_o),     32'(held.de));
        chk("async_rst_hsync",  32'(h_sync_o), 32'(held.hs));
        chk("async_rst_vsync",  32'(v_sync_o), 32'(held.vs));
        chk("async_rst_irq",    32'(irq),      32'(held.irq));
        reset_cycles(2);
        repeat (FRAME + 20) cyc(1'b1, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
